// File: rtl/device_lpif_resp.sv
// device_lpif_resp: LPIF device-side request decoder and in-order response queue.
// Writes/reads from received flits drive one-cycle memory strobes, ride an
// RD_LAT-deep pipeline, and land in a RSP_DEPTH-entry response queue whose head
// is presented as NDR/DRS flits on the LPIF transmit side.
// Build macro DEVICE_LPIF_RESP_CRC_EN adds a combinational CRC-16 over lp_data.
module device_lpif_resp #(
    parameter int DATA_W    = 512,
    parameter int MEM_W     = 128,
    parameter int RSP_DEPTH = 4,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_online,
    input  logic              rx_online,
    input  logic              align_done,
    input  logic              align_error,
    input  logic              pl_exit_cg_req,
    input  logic              pl_trdy,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              lp_exit_cg_ack,
    output logic [3:0]        lp_state_req,
    output logic              lp_valid,
    output logic              lp_irdy,
    output logic [DATA_W-1:0] lp_data,
    output logic [15:0]       crc_data,
    output logic              crc_data_valid,
    output logic [31:0]       mem_addr,
    output logic [MEM_W-1:0]  mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic              ovf_err
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + RD_LAT + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CG_WAIT, S_RUN} state_e;

    typedef struct packed {
        logic        rd;
        logic [7:0]  tag;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic             rd;
        logic [7:0]       tag;
        logic [31:0]      addr;
        logic [MEM_W-1:0] data;
    } rsp_t;

    state_e             state_q;
    logic               req_dly_q;
    logic               phy_ready;
    logic               mem_wr_q, mem_rd_q, ovf_q;
    logic [31:0]        mem_addr_q;
    logic [MEM_W-1:0]   mem_wdata_q;
    logic [RD_LAT-1:0]  pv_q;
    req_t               pipe_q [RD_LAT];
    rsp_t               q_mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     cnt_q;
    logic [CNT_W-1:0]   credit;
    logic [3:0]         op;
    logic               is_wr, is_rd, req_hit, accept, drop, push, pop;
    logic [DATA_W-1:0]  rsp_flit;
    rsp_t               head;
    logic               unused_pl;

    // Reserved flit fields carry nothing for this responder.
    assign unused_pl = ^pl_data;

    assign phy_ready = align_done & tx_online & rx_online & ~align_error;

    assign op      = pl_data[3:0];
    assign is_wr   = (op == 4'h1);
    assign is_rd   = (op == 4'h2);
    assign req_hit = (state_q == S_RUN) && phy_ready && pl_valid && (is_wr || is_rd);
    assign pop     = (cnt_q != '0) && pl_trdy;
    assign push    = pv_q[RD_LAT-1];

    // Outstanding work = queued + in flight; a pop this cycle frees its slot immediately.
    always_comb begin
        credit = CNT_W'(cnt_q) - CNT_W'(pop);
        for (int i = 0; i < RD_LAT; i++) credit = credit + CNT_W'(pv_q[i]);
    end

    assign accept = req_hit && (credit < CNT_W'(RSP_DEPTH));
    assign drop   = req_hit && !accept;

    // Link FSM: leave IDLE on PHY ready, enter RUN once the clock-gate exit handshake closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_dly_q <= 1'b0;
        end else begin
            req_dly_q <= pl_exit_cg_req;
            if (!phy_ready) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:    state_q <= S_CG_WAIT;
                    S_CG_WAIT: if (!pl_exit_cg_req && lp_exit_cg_ack) state_q <= S_RUN;
                    default:   state_q <= state_q;
                endcase
            end
        end
    end

    assign lp_exit_cg_ack = (state_q != S_IDLE) && req_dly_q;
    assign lp_state_req   = {3'b000, state_q != S_IDLE};

    // Memory strobes and address/data capture for accepted requests; sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            mem_wr_q <= accept && is_wr;
            mem_rd_q <= accept && is_rd;
            if (accept) mem_addr_q <= pl_data[91:60];
            if (accept && is_wr) mem_wdata_q <= pl_data[128+MEM_W-1:128];
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ovf_err   = ovf_q;

    // Latency pipeline feeding the response queue; link loss flushes both.
    always_ff @(posedge clk) begin
        if (reset || !phy_ready) begin
            pv_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pv_q[0]          <= accept;
            pipe_q[0].rd     <= is_rd;
            pipe_q[0].tag    <= pl_data[15:8];
            pipe_q[0].addr   <= pl_data[91:60];
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
            if (push) begin
                q_mem[wr_ptr_q].rd   <= pipe_q[RD_LAT-1].rd;
                q_mem[wr_ptr_q].tag  <= pipe_q[RD_LAT-1].tag;
                q_mem[wr_ptr_q].addr <= pipe_q[RD_LAT-1].addr;
                q_mem[wr_ptr_q].data <= pipe_q[RD_LAT-1].rd ? mem_rdata : '0;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head entry formatted as an NDR/DRS flit; all-zero when nothing is queued.
    always_comb begin
        head     = q_mem[rd_ptr_q];
        rsp_flit = '0;
        if (cnt_q != '0) begin
            rsp_flit[3:0]             = head.rd ? 4'h5 : 4'h4;
            rsp_flit[15:8]            = head.tag;
            rsp_flit[91:60]           = head.addr;
            rsp_flit[128+MEM_W-1:128] = head.data;
        end
    end

    assign lp_data  = rsp_flit;
    assign lp_valid = (cnt_q != '0);
    assign lp_irdy  = (cnt_q != '0);

`ifdef DEVICE_LPIF_RESP_CRC_EN
    function automatic logic [15:0] crc16(input logic [DATA_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    assign crc_data       = crc16(lp_data);
    assign crc_data_valid = lp_valid;
`else
    assign crc_data       = 16'h0000;
    assign crc_data_valid = 1'b0;
`endif

endmodule
